// File: rtl/data_ram_load_unit.sv
// Byte-lane data RAM with write-first read path and a registered load-extraction stage.
// Load results are sign/zero-extended per load type; misaligned loads return zero with addr_err.
module data_ram_load_unit #(
    parameter int ADDR_BITS = 10,
    parameter int DATA_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [1:0]           byte_off,
    input  logic [DATA_BITS-1:0] mem_in,
    input  logic [3:0]           mem_sel,
    input  logic                 mem_write,
    input  logic                 mem_read,
    input  logic                 Lb,
    input  logic                 Lbu,
    input  logic                 Lh,
    input  logic                 Lhu,
    output logic [DATA_BITS-1:0] load_data,
    output logic                 load_valid,
    output logic                 addr_err,
    input  logic [ADDR_BITS-1:0] dbg_addr,
    output logic [DATA_BITS-1:0] dbg_data
);

    typedef enum logic [2:0] {
        LD_W,
        LD_HU,
        LD_H,
        LD_BU,
        LD_B
    } load_type_t;

    logic [DATA_BITS-1:0] mem [0:(1 << ADDR_BITS) - 1];

    logic [DATA_BITS-1:0] read_word;
    logic [7:0]           byte_val;
    logic [15:0]          half_val;
    logic [DATA_BITS-1:0] ext_data;
    logic                 misaligned;
    load_type_t           load_type;

    // Storage is never reset; only the output registers respond to rst.
    always_ff @(posedge clk) begin
        if (mem_write) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (mem_sel[i]) begin
                    mem[addr][8*i +: 8] <= mem_in[8*i +: 8];
                end
            end
        end
    end

    assign dbg_data = mem[dbg_addr];

    // Write-first: lanes being written this edge bypass the array into the load path.
    always_comb begin
        read_word = mem[addr];
        for (int unsigned i = 0; i < 4; i++) begin
            if (mem_write && mem_sel[i]) begin
                read_word[8*i +: 8] = mem_in[8*i +: 8];
            end
        end
    end

    always_comb begin
        load_type = LD_W;
        if (Lb) begin
            load_type = LD_B;
        end else if (Lbu) begin
            load_type = LD_BU;
        end else if (Lh) begin
            load_type = LD_H;
        end else if (Lhu) begin
            load_type = LD_HU;
        end
    end

    always_comb begin
        byte_val = read_word[7:0];
        case (byte_off)
            2'd0: byte_val = read_word[7:0];
            2'd1: byte_val = read_word[15:8];
            2'd2: byte_val = read_word[23:16];
            2'd3: byte_val = read_word[31:24];
            default: byte_val = read_word[7:0];
        endcase
        half_val = byte_off[1] ? read_word[31:16] : read_word[15:0];
    end

    always_comb begin
        ext_data   = '0;
        misaligned = 1'b0;
        case (load_type)
            LD_B:  ext_data = {{24{byte_val[7]}}, byte_val};
            LD_BU: ext_data = {24'd0, byte_val};
            LD_H: begin
                misaligned = byte_off[0];
                ext_data   = {{16{half_val[15]}}, half_val};
            end
            LD_HU: begin
                misaligned = byte_off[0];
                ext_data   = {16'd0, half_val};
            end
            default: begin
                misaligned = (byte_off != 2'd0);
                ext_data   = read_word;
            end
        endcase
        if (misaligned) begin
            ext_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            load_data  <= '0;
            load_valid <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            load_valid <= mem_read;
            if (mem_read) begin
                load_data <= ext_data;
                addr_err  <= misaligned;
            end
        end
    end

endmodule
